// File: rtl/ysyx_22050550_wb_arbiter_if.sv
// ============================================================================
// ysyx_22050550_wb_arbiter_if : EXU/LSU result inputs, regfile/scoreboard
// write outputs and commit trace of the writeback arbiter.  Rev 1.0
// ============================================================================
`default_nettype none

interface ysyx_22050550_wb_arbiter_if #(
  parameter int DW  = 64,
  parameter int PCW = 64
);
  logic           exu_valid;
  logic           exu_ready;
  logic           exu_wen;
  logic [4:0]     exu_waddr;
  logic [DW-1:0]  exu_wdata;
  logic [PCW-1:0] exu_pc;

  logic           lsu_valid;
  logic           lsu_ready;
  logic           lsu_wen;
  logic [4:0]     lsu_waddr;
  logic [DW-1:0]  lsu_wdata;
  logic [PCW-1:0] lsu_pc;

  logic           rf_wen;
  logic [4:0]     rf_waddr;
  logic [DW-1:0]  rf_wdata;
  logic           sb_wen;
  logic [4:0]     sb_waddr;
  logic           commit_valid;
  logic [PCW-1:0] commit_pc;

  // Arbiter side
  modport slave (
    input  exu_valid, exu_wen, exu_waddr, exu_wdata, exu_pc,
    input  lsu_valid, lsu_wen, lsu_waddr, lsu_wdata, lsu_pc,
    output exu_ready, lsu_ready,
    output rf_wen, rf_waddr, rf_wdata, sb_wen, sb_waddr,
    output commit_valid, commit_pc
  );

  // Producer / observer side
  modport master (
    output exu_valid, exu_wen, exu_waddr, exu_wdata, exu_pc,
    output lsu_valid, lsu_wen, lsu_waddr, lsu_wdata, lsu_pc,
    input  exu_ready, lsu_ready,
    input  rf_wen, rf_waddr, rf_wdata, sb_wen, sb_waddr,
    input  commit_valid, commit_pc
  );
endinterface

`default_nettype wire

// File: rtl/ysyx_22050550_wb_arbiter.sv
// ============================================================================
// ysyx_22050550_wb_arbiter : merges EXU and LSU results into one regfile write
// and scoreboard clear per cycle. Optional YSYX_22050550_WB_DIFFTEST_EN. Rev 1.0
// ============================================================================
`default_nettype none

module ysyx_22050550_wb_arbiter #(
  parameter int DW           = 64,
  parameter int PCW          = 64,
  parameter int STARVE_LIMIT = 3
) (
  input  logic                             clock,
  input  logic                             reset,
  ysyx_22050550_wb_arbiter_if.slave        wb
);

  localparam logic [3:0] C_STARVE_LIMIT = 4'(STARVE_LIMIT);

  logic [3:0]     r_starve_cnt;
  logic           w_grant_exu;
  logic           w_grant_lsu;
  logic           w_xfer;
  logic           w_sel_wen;
  logic [4:0]     w_sel_waddr;
  logic [DW-1:0]  w_sel_wdata;

  logic           r_rf_wen;
  logic [4:0]     r_rf_waddr;
  logic [DW-1:0]  r_rf_wdata;

  // LSU wins ties until EXU has lost STARVE_LIMIT times in a row; nothing is
  // granted while reset is held low.
  always_comb begin
    w_grant_exu = 1'b0;
    w_grant_lsu = 1'b0;
    if (reset) begin
      w_grant_exu = wb.exu_valid && (!wb.lsu_valid || (r_starve_cnt == C_STARVE_LIMIT));
      w_grant_lsu = wb.lsu_valid && !w_grant_exu;
    end
  end

  assign w_xfer       = w_grant_exu || w_grant_lsu;
  assign wb.exu_ready = w_grant_exu;
  assign wb.lsu_ready = w_grant_lsu;

  always_comb begin
    w_sel_wen   = 1'b0;
    w_sel_waddr = 5'd0;
    w_sel_wdata = '0;
    if (w_grant_exu) begin
      w_sel_wen   = wb.exu_wen;
      w_sel_waddr = wb.exu_waddr;
      w_sel_wdata = wb.exu_wdata;
    end else if (w_grant_lsu) begin
      w_sel_wen   = wb.lsu_wen;
      w_sel_waddr = wb.lsu_waddr;
      w_sel_wdata = wb.lsu_wdata;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_starve_cnt <= 4'd0;
    end else if (w_grant_exu) begin
      r_starve_cnt <= 4'd0;
    end else if (w_grant_lsu && wb.exu_valid) begin
      r_starve_cnt <= r_starve_cnt + 4'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_rf_wen   <= 1'b0;
      r_rf_waddr <= 5'd0;
      r_rf_wdata <= '0;
    end else begin
      r_rf_wen <= w_xfer && w_sel_wen && (w_sel_waddr != 5'd0);
      if (w_xfer) begin
        r_rf_waddr <= w_sel_waddr;
        r_rf_wdata <= w_sel_wdata;
      end
    end
  end

  // The scoreboard clear is the regfile write seen from the other side.
  assign wb.rf_wen   = r_rf_wen;
  assign wb.rf_waddr = r_rf_waddr;
  assign wb.rf_wdata = r_rf_wdata;
  assign wb.sb_wen   = r_rf_wen;
  assign wb.sb_waddr = r_rf_waddr;

`ifdef YSYX_22050550_WB_DIFFTEST_EN
  logic           r_commit_valid;
  logic [PCW-1:0] r_commit_pc;
  logic [PCW-1:0] w_sel_pc;

  assign w_sel_pc = w_grant_exu ? wb.exu_pc : wb.lsu_pc;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_commit_valid <= 1'b0;
      r_commit_pc    <= '0;
    end else begin
      r_commit_valid <= w_xfer;
      if (w_xfer) begin
        r_commit_pc <= w_sel_pc;
      end
    end
  end

  assign wb.commit_valid = r_commit_valid;
  assign wb.commit_pc    = r_commit_pc;
`else
  logic [PCW-1:0] w_unused_pc;

  assign w_unused_pc     = wb.exu_pc ^ wb.lsu_pc;
  assign wb.commit_valid = 1'b0;
  assign wb.commit_pc    = '0;
`endif

endmodule

`default_nettype wire
